// File: rtl/des_pkg.sv
// Shared DES constants: widths, FSM states, key rotation schedule and the
// IP/FP/PC1/PC2 bit permutations. Tables use DES numbering (bit 1 = MSB).
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left-rotation amount applied before encrypt rounds 1..16
  localparam int SHIFT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [63:0] des_ip(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = d[64-IP_T[i]];
    return o;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[63-i] = d[64-FP_T[i]];
    return o;
  endfunction

  // Parity bits 8,16,..,64 are simply never selected
  function automatic logic [55:0] des_pc1(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
    return o;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] cd);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
    return o;
  endfunction

  // Rotation amount for round index idx (0-based); decrypt walks the schedule backwards
  function automatic logic [1:0] key_shift(input logic [3:0] idx, input logic dec);
    logic [1:0] s;
    if (!dec)          s = 2'(SHIFT_ENC[idx]);
    else if (idx == 0) s = 2'd0;
    else               s = 2'(SHIFT_ENC[4'(16 - int'(idx))]);
    return s;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] o;
    case (n)
      2'd1:    o = {x[26:0], x[27]};
      2'd2:    o = {x[25:0], x[27:26]};
      default: o = x;
    endcase
    return o;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] o;
    case (n)
      2'd1:    o = {x[0], x[27:1]};
      2'd2:    o = {x[1:0], x[27:2]};
      default: o = x;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/Feistel_Function.sv
// DES f-function: expansion, subkey mix, S-box substitution, P permutation.
// Purely combinational.
module Feistel_Function (
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each S-box is 4 rows x 16 columns of nibbles, row-major, first entry in the MSBs
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[47-i] = r[32-E_T[i]];
    return o;
  endfunction

  // Outer bits of each 6-bit group pick the row, inner four the column
  function automatic logic [31:0] substitute(input logic [47:0] x);
    logic [31:0] s;
    logic [5:0]  six;
    int          n;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      n   = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
      s[31-4*b -: 4] = SBOX[b][255-4*n -: 4];
    end
    return s;
  endfunction

  function automatic logic [31:0] permute_p(input logic [31:0] s);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
    return o;
  endfunction

  assign o_f = permute_p(substitute(expand(i_r) ^ i_k));

endmodule

// File: rtl/des_round.sv
// One DES round together with its key-schedule step. Rotation direction and
// amount depend on the absolute round index and on the mode.
module des_round
  import des_pkg::*;
(
  input  logic [31:0]         i_l,
  input  logic [31:0]         i_r,
  input  logic [HALF_W-1:0]   i_c,
  input  logic [HALF_W-1:0]   i_d,
  input  logic [3:0]          i_idx,
  input  logic                i_dec,
  output logic [31:0]         o_l,
  output logic [31:0]         o_r,
  output logic [HALF_W-1:0]   o_c,
  output logic [HALF_W-1:0]   o_d
);

  logic [1:0]          w_sh;
  logic [HALF_W-1:0]   w_c;
  logic [HALF_W-1:0]   w_d;
  logic [SUBKEY_W-1:0] w_k;
  logic [31:0]         w_f;

  assign w_sh = key_shift(i_idx, i_dec);
  assign w_c  = i_dec ? rotr28(i_c, w_sh) : rotl28(i_c, w_sh);
  assign w_d  = i_dec ? rotr28(i_d, w_sh) : rotl28(i_d, w_sh);
  assign w_k  = des_pc2({w_c, w_d});

  Feistel_Function u_f (
    .i_r (i_r),
    .i_k (w_k),
    .o_f (w_f)
  );

  assign o_l = i_r;
  assign o_r = i_l ^ w_f;
  assign o_c = w_c;
  assign o_d = w_d;

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES core: accepts a block/key/mode, runs 16 rounds at
// ROUNDS_PER_CYCLE rounds per clock, holds the result until taken.
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  in_data,
  input  logic [KEY_W-1:0]    in_key,
  input  logic                in_decrypt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_data,
  output logic                busy
);

  localparam int ITERS = 16 / ROUNDS_PER_CYCLE;
  localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_l;
  logic [31:0]         r_r;
  logic [HALF_W-1:0]   r_c;
  logic [HALF_W-1:0]   r_d;
  logic                r_dec;
  logic [3:0]          r_cnt;
  logic [BLOCK_W-1:0]  r_out;

  logic                w_load;
  logic                w_step;
  logic                w_last;
  logic [63:0]         w_ip;
  logic [55:0]         w_pc1;

  logic [31:0]         w_l   [ROUNDS_PER_CYCLE+1];
  logic [31:0]         w_r   [ROUNDS_PER_CYCLE+1];
  logic [HALF_W-1:0]   w_c   [ROUNDS_PER_CYCLE+1];
  logic [HALF_W-1:0]   w_d   [ROUNDS_PER_CYCLE+1];
  logic [3:0]          w_idx [ROUNDS_PER_CYCLE];

  assign w_ip  = des_ip(in_data);
  assign w_pc1 = des_pc1(in_key);

  assign w_l[0] = r_l;
  assign w_r[0] = r_r;
  assign w_c[0] = r_c;
  assign w_d[0] = r_d;

  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    assign w_idx[k] = 4'(int'(r_cnt) * ROUNDS_PER_CYCLE + k);

    des_round u_round (
      .i_l   (w_l[k]),
      .i_r   (w_r[k]),
      .i_c   (w_c[k]),
      .i_d   (w_d[k]),
      .i_idx (w_idx[k]),
      .i_dec (r_dec),
      .o_l   (w_l[k+1]),
      .o_r   (w_r[k+1]),
      .o_c   (w_c[k+1]),
      .o_d   (w_d[k+1])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and handshake outputs (outputs depend on state only)
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Block/key load, round iteration and final swap + FP into the result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l   <= '0;
      r_r   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_dec <= 1'b0;
      r_cnt <= '0;
      r_out <= '0;
    end else if (w_load) begin
      r_l   <= w_ip[63:32];
      r_r   <= w_ip[31:0];
      r_c   <= w_pc1[55:28];
      r_d   <= w_pc1[27:0];
      r_dec <= in_decrypt;
      r_cnt <= '0;
    end else if (w_step) begin
      r_l <= w_l[ROUNDS_PER_CYCLE];
      r_r <= w_r[ROUNDS_PER_CYCLE];
      r_c <= w_c[ROUNDS_PER_CYCLE];
      r_d <= w_d[ROUNDS_PER_CYCLE];
      if (w_last) r_out <= des_fp({w_r[ROUNDS_PER_CYCLE], w_l[ROUNDS_PER_CYCLE]});
      else        r_cnt <= r_cnt + 4'd1;
    end
  end

  assign out_data = r_out;

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: one instance per legal ROUNDS_PER_CYCLE, driven
// with known-answer DES vectors and checked against a transaction-level model.
`timescale 1ns/1ps
module tb_des_iter_core;

  localparam int N = 5;   // instance g uses ROUNDS_PER_CYCLE = 1 << g

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;

  localparam int NV = 7;
  localparam logic [63:0] V_D [NV] = '{P1, C1, 64'h8787878787878787, 64'h0,
                                       64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h8CA64DE9C1B123A7};
  localparam logic [63:0] V_K [NV] = '{K1, K1, K2, K2, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0};
  localparam logic        V_M [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [63:0] V_E [NV] = '{C1, P1, 64'h0, 64'h8787878787878787,
                                       64'h8CA64DE9C1B123A7, 64'h7359B2163E4EDC58, 64'h0};

  logic          clk;
  logic          rst;
  logic [N-1:0]  tb_in_valid;
  logic [N-1:0]  tb_out_ready;
  logic [63:0]   tb_in_data;
  logic [63:0]   tb_in_key;
  logic          tb_in_decrypt;
  logic [N-1:0]  w_in_ready;
  logic [N-1:0]  w_out_valid;
  logic [N-1:0]  w_busy;
  logic [63:0]   w_out_data [N];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (tb_in_valid[g]),
      .in_ready   (w_in_ready[g]),
      .in_data    (tb_in_data),
      .in_key     (tb_in_key),
      .in_decrypt (tb_in_decrypt),
      .out_valid  (w_out_valid[g]),
      .out_ready  (tb_out_ready[g]),
      .out_data   (w_out_data[g]),
      .busy       (w_busy[g])
    );
  end

  task automatic check(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s R=%0d actual=%h required=%h @%0t", name, 1 << inst, act, req, $time);
    end
  endtask

  // Transaction model: expected result per block comes from the stimulus
  logic [N-1:0] m_rdy, m_ov, m_busy, m_zero;
  int           m_left [N];
  logic [63:0]  m_out  [N];
  logic [63:0]  m_lat  [N];
  logic [63:0]  tb_exp [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_rdy[i]  <= 1'b1;
        m_ov[i]   <= 1'b0;
        m_busy[i] <= 1'b0;
        m_zero[i] <= 1'b1;
        m_out[i]  <= 64'h0;
        m_left[i] <= 0;
      end else if (m_rdy[i] && tb_in_valid[i]) begin
        m_rdy[i]  <= 1'b0;
        m_busy[i] <= 1'b1;
        m_zero[i] <= 1'b0;
        m_left[i] <= 16 >> i;
        m_lat[i]  <= tb_exp[i];
      end else if (m_busy[i]) begin
        if (m_left[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_ov[i]   <= 1'b1;
          m_out[i]  <= m_lat[i];
        end else begin
          m_left[i] <= m_left[i] - 1;
        end
      end else if (m_ov[i] && tb_out_ready[i]) begin
        m_ov[i]  <= 1'b0;
        m_rdy[i] <= 1'b1;
      end
    end
  end

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        check("in_ready", i, 64'(w_in_ready[i]), 64'(m_rdy[i]));
        check("out_valid", i, 64'(w_out_valid[i]), 64'(m_ov[i]));
        check("busy", i, 64'(w_busy[i]), 64'(m_busy[i]));
        if (m_ov[i] || m_zero[i]) check("out_data", i, w_out_data[i], m_out[i]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge
  task automatic send(input int i, input logic [63:0] d, input logic [63:0] k,
                      input logic dec, input logic [63:0] e);
    int n = 0;
    while (!w_in_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", i, 64'(w_in_ready[i]), 64'd1);
    tb_exp[i]      = e;
    tb_in_data     = d;
    tb_in_key      = k;
    tb_in_decrypt  = dec;
    tb_in_valid[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_in_valid[i] = 1'b0;
  endtask

  // Waits (bounded) for out_valid, pins latency and value, optionally takes the result
  task automatic collect(input int i, input logic [63:0] e, input bit take);
    int lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!w_out_valid[i] && lat < 40);
    check("latency", i, 64'(lat), 64'(16 >> i));
    check("result", i, w_out_data[i], e);
    if (take) begin
      tb_out_ready[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tb_out_ready[i] = 1'b0;
      check("ready_after_take", i, 64'(w_in_ready[i]), 64'd1);
      check("valid_after_take", i, 64'(w_out_valid[i]), 64'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    tb_in_valid   = '0;
    tb_out_ready  = '0;
    tb_in_data    = '0;
    tb_in_key     = '0;
    tb_in_decrypt = 1'b0;
    for (int i = 0; i < N; i++) tb_exp[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      check("rst_in_ready", i, 64'(w_in_ready[i]), 64'd1);
      check("rst_out_valid", i, 64'(w_out_valid[i]), 64'd0);
      check("rst_busy", i, 64'(w_busy[i]), 64'd0);
      check("rst_out_data", i, w_out_data[i], 64'h0);
    end

    for (int i = 0; i < N; i++) begin
      // Known-answer encrypt/decrypt vectors
      for (int v = 0; v < NV; v++) begin
        send(i, V_D[v], V_K[v], V_M[v], V_E[v]);
        collect(i, V_E[v], 1'b1);
      end

      // Key and mode scrambled after accept must not disturb the block in flight
      send(i, P1, K1, 1'b0, C1);
      tb_in_key     = 64'hFFFFFFFFFFFFFFFF;
      tb_in_decrypt = 1'b1;
      collect(i, C1, 1'b1);

      // Backpressure: hold the result for 20 clocks with a stray in_valid pulse
      send(i, P1, K1, 1'b0, C1);
      collect(i, C1, 1'b0);
      for (int c = 0; c < 20; c++) begin
        if (c == 5) begin
          tb_exp[i]      = 64'hDEADBEEFDEADBEEF;
          tb_in_data     = 64'h0;
          tb_in_key      = 64'h0;
          tb_in_valid[i] = 1'b1;
        end
        if (c == 6) tb_in_valid[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold_data", i, w_out_data[i], C1);
        check("hold_in_ready", i, 64'(w_in_ready[i]), 64'd0);
        check("hold_out_valid", i, 64'(w_out_valid[i]), 64'd1);
      end
      tb_out_ready[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tb_out_ready[i] = 1'b0;
      check("release_in_ready", i, 64'(w_in_ready[i]), 64'd1);
      check("release_out_valid", i, 64'(w_out_valid[i]), 64'd0);

      // Reset with the round counter at ITERS/2, then a fresh block
      send(i, P1, K1, 1'b0, C1);
      repeat ((16 >> i) / 2) begin
        @(posedge clk);
        @(negedge clk);
      end
      check("busy_before_abort", i, 64'(w_busy[i]), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", i, 64'(w_in_ready[i]), 64'd1);
      check("abort_out_valid", i, 64'(w_out_valid[i]), 64'd0);
      check("abort_busy", i, 64'(w_busy[i]), 64'd0);
      send(i, P1, K1, 1'b0, C1);
      collect(i, C1, 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
- Parametrised iterative DES block cipher core built around the team's existing combinational Feistel_Function.
- Accepts one 64-bit block plus a 64-bit key and a mode bit over a valid/ready handshake.
- Runs 16 Feistel rounds, ROUNDS_PER_CYCLE rounds per clock, with an on-the-fly key schedule (encrypt or decrypt).
- Returns the ciphertext/plaintext over a valid/ready output handshake. It is the next layer above the f-function, sitting between the host interface and the round logic.

Parameters:
- ROUNDS_PER_CYCLE, 1, Feistel rounds unrolled per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration-time error.
- ITERS, 16/ROUNDS_PER_CYCLE, derived (localparam). Number of round clocks per block.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_key/in_decrypt are valid
- in_ready  output  1  core can accept a block
- in_data  input  64  plaintext (encrypt) or ciphertext (decrypt), bit 63 = DES bit 1
- in_key  input  64  DES key incl. parity bits (parity ignored)
- in_decrypt  input  1  0 = encrypt, 1 = decrypt
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  consumer takes result
- out_data  output  64  result block, bit 63 = DES bit 1
- busy  output  1  high while in RUN

Behaviour:
- Reset: rst sampled on a clock edge gives state=IDLE, round counter=0, and data/key registers=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, busy=0. rst overrides every other input, including mid-RUN and DONE; any in-flight block is discarded with no output.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - Load L/R = IP(in_data).
    - Load C/D = PC1(in_key).
    - Latch the mode bit.
    - Clear the counter and go to RUN.
  - RUN: in_ready=0, busy=1. Each clock applies ROUNDS_PER_CYCLE chained rounds, with the round index = counter*ROUNDS_PER_CYCLE + k (k = 0..ROUNDS_PER_CYCLE-1).
    - When counter == ITERS-1, register the final L16/R16 swap and FP into out_data, then go to DONE.
    - Otherwise increment the counter.
  - DONE: out_valid=1, out_data stable. On out_ready=1 go to IDLE (in_ready rises the next cycle, not combinationally). While out_ready=0, hold indefinitely; in_valid is ignored.
- Round step: L' = R; R' = L ^ Feistel_Function(R, K).
- Key schedule, encrypt: before round i (1..16), rotate C and D left by SHIFT_ENC[i], then K = PC2(C,D).
- Key schedule, decrypt: round 1 uses K = PC2(C0,D0) with no shift. Before rounds 2..16, rotate C and D right by SHIFT_DEC[i] = SHIFT_ENC[18-i]. This produces K16..K1 in order.
- Rotation wrap-around is within each 28-bit half independently.
- Output preswap: out_data = FP({R16, L16}).
- Latency: the accept edge is E0; out_valid is high after edge E(ITERS) (16 clocks for R=1, 1 clock for R=16). Back-to-back throughput is one block per ITERS+2 clocks with out_ready tied high.
- Mode and key are latched at accept. Changes to in_* during RUN/DONE have no effect.
- in_ready is a pure function of state. There is no combinational path from in_valid or out_ready to any output.
- Parity bits 8, 16, ..., 64 are dropped by PC1 and never checked.

Decomposition:
- Package des_pkg holds:
  - IP, FP, PC1 and PC2 permutation tables as constant functions;
  - SHIFT_ENC[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1;
  - the state enum (IDLE/RUN/DONE);
  - width constants BLOCK_W=64, KEY_W=64, HALF_W=28, SUBKEY_W=48.
- One sub-module, des_round: one Feistel round plus its key-schedule step (shift/rotate, PC2, Feistel_Function instance). It is generated ROUNDS_PER_CYCLE times in a combinational chain. Feistel_Function is reused unchanged.

Test Plan:
- Encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF -> out_data 85E813540F0AB405 after exactly ITERS clocks. Run for every legal ROUNDS_PER_CYCLE.
- Decrypt, same key, data 85E813540F0AB405 -> 0123456789ABCDEF. Then encrypt with key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000.
- All-zero key and data, encrypt -> 8CA64DE9C1B123A7. Key FFFFFFFFFFFFFFFF, data FFFFFFFFFFFFFFFF -> 7359B2163E4EDC58.
- Backpressure: hold out_ready=0 for 20 clocks after out_valid. Check out_data stable, in_ready=0, and that an in_valid pulse is ignored. Then release out_ready: one transfer, and in_ready=1 on the following clock.
- Reset mid-RUN at counter=ITERS/2: the next cycle shows in_ready=1, out_valid=0, busy=0. A fresh 0123456789ABCDEF encrypt then still yields 85E813540F0AB405.
- Change in_key/in_decrypt during RUN: the result equals the value for the key/mode latched at accept.
